// File: rtl/mem_rr_arbiter_pkg.sv
// cache_defs: arbiter state type and cache requester indices shared by the memory arbiter.
package cache_defs;
   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DRAIN} type_mem_rr_states_e;
   localparam int REQ_DCACHE = 0;
   localparam int REQ_ICACHE = 1;
   localparam int REQ_PTW    = 2;
endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: stateless round-robin search over req, starting at ptr and wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);
   logic [IW-1:0] k;
   logic          found;
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = IW'((int'(ptr) + i) % NREQ);
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter multiplexing cache line requests onto one main-memory port.
// A killed transaction drains until memory acks or the drain timeout expires.
module mem_rr_arbiter
   import cache_defs::*;
#(
   parameter int         NREQ    = 3,
   parameter int         ADDR_W  = 32,
   parameter int         LINE_W  = 128,
   parameter logic [7:0] TIMEOUT = 8'hEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ-1:0]        kill_i,
   input  logic [NREQ-1:0]        w_en_i,
   input  logic [NREQ*ADDR_W-1:0] addr_i,
   input  logic [NREQ*LINE_W-1:0] w_data_i,
   output logic [NREQ-1:0]        ack_o,
   output logic [LINE_W-1:0]      r_data_o,
   output logic                   mem_req_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic                   mem_w_en_o,
   output logic [LINE_W-1:0]      mem_w_data_o,
   input  logic                   mem_ack_i,
   input  logic [LINE_W-1:0]      mem_r_data_i,
   output logic [NREQ-1:0]        grant_o,
   output logic                   timeout_o
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   type_mem_rr_states_e state, state_n;
   logic [IW-1:0]   ptr, owner, pick_idx, ptr_nxt;
   logic [NREQ-1:0] pick_grant;
   logic [7:0]      cnt;
   logic            owner_kill;
   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req_i),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );
   assign owner_kill = kill_i[owner];
   assign ptr_nxt    = owner == IW'(NREQ - 1) ? '0 : owner + IW'(1);
   assign r_data_o   = |ack_o ? mem_r_data_i : '0;
   always_comb begin
      state_n   = state;
      ack_o     = '0;
      timeout_o = 1'b0;
      case (state)
         ARB_IDLE: state_n = |req_i ? ARB_BUSY : ARB_IDLE;
         ARB_BUSY: begin
            state_n = mem_ack_i ? ARB_IDLE : owner_kill ? ARB_DRAIN : ARB_BUSY;
            ack_o   = (mem_ack_i && !owner_kill) ? grant_o : '0;
         end
         ARB_DRAIN: begin
            timeout_o = !mem_ack_i && cnt == TIMEOUT;
            state_n   = (mem_ack_i || cnt == TIMEOUT) ? ARB_IDLE : ARB_DRAIN;
         end
         default: state_n = ARB_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ARB_IDLE;
         ptr          <= '0;
         owner        <= '0;
         cnt          <= '0;
         grant_o      <= '0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
         mem_w_en_o   <= 1'b0;
         mem_w_data_o <= '0;
      end else begin
         state <= state_n;
         cnt   <= state == ARB_DRAIN ? cnt + 8'd1 : 8'd0;
         if (state == ARB_IDLE && |req_i) begin
            owner        <= pick_idx;
            grant_o      <= pick_grant;
            mem_req_o    <= 1'b1;
            mem_addr_o   <= addr_i[pick_idx*ADDR_W +: ADDR_W];
            mem_w_en_o   <= w_en_i[pick_idx];
            mem_w_data_o <= w_data_i[pick_idx*LINE_W +: LINE_W];
         end
         // Leaving BUSY by any path (ack, kill, or both) hands priority to the next requester.
         if (state == ARB_BUSY && state_n != ARB_BUSY) begin
            grant_o <= '0;
            ptr     <= ptr_nxt;
         end
         if (state != ARB_IDLE && state_n == ARB_IDLE) mem_req_o <= 1'b0;
      end
   end
endmodule
